// File: rtl/ex_mem.sv
// EX->MEM pipeline register; also parks the madd/msub partial accumulation for EX.
// Latency: 1 cycle from ex_* to mem_*, no combinational input-to-output path.
// Backpressure: stall[3] && !stall[4] inserts a bubble; stall[3] && stall[4] holds; flush overrides both.
module ex_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic                ex_whilo,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_whilo,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [CNT_W-1:0]    cnt_o
);

    // One MEM-stage instruction slot; an all-zero slot is the bubble (NOP to r0, no writes).
    typedef struct packed {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              whilo;
    } slot_t;

    slot_t               ex_slot;
    slot_t               mem_slot;
    logic [2*DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ex_stall;
    logic                mem_stall;
    logic                unused_stall;

    assign ex_stall     = stall[3];
    assign mem_stall    = stall[4];
    // Only the EX and MEM stall bits matter to this boundary.
    assign unused_stall = ^{stall[5], stall[2:0]};

    // Gather the EX results into one slot so they move together.
    always_comb begin
        ex_slot       = '0;
        ex_slot.wd    = ex_wd;
        ex_slot.wreg  = ex_wreg;
        ex_slot.wdata = ex_wdata;
        ex_slot.hi    = ex_hi;
        ex_slot.lo    = ex_lo;
        ex_slot.whilo = ex_whilo;
    end

    // Pipeline slot plus accumulator parking; flush beats stall, full stall holds everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_slot <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            mem_slot <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (ex_stall && !mem_stall) begin
            // EX is mid madd/msub: MEM gets a bubble, partial result is parked for EX.
            mem_slot <= '0;
            acc_q    <= hilo_i;
            cnt_q    <= cnt_i;
        end else if (!ex_stall) begin
            mem_slot <= ex_slot;
            acc_q    <= '0;
            cnt_q    <= '0;
        end
    end

    assign mem_wd    = mem_slot.wd;
    assign mem_wreg  = mem_slot.wreg;
    assign mem_wdata = mem_slot.wdata;
    assign mem_hi    = mem_slot.hi;
    assign mem_lo    = mem_slot.lo;
    assign mem_whilo = mem_slot.whilo;
    assign hilo_o    = acc_q;
    assign cnt_o     = cnt_q;

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the EX and MEM stages of the 5-stage MIPS32 core.
- Latches EX results each cycle and presents them to the MEM stage: destination register, write enable, write data, HI/LO values and the HI/LO write enable.
- Honours the pipeline stall vector and a flush input.
- Holds the partial 64-bit accumulation and cycle counter for two-cycle madd/maddu/msub/msubu, returning them to EX while EX is stalled.

Parameters:
- DATA_W, 32, general-purpose register / HI / LO width.
- ADDR_W, 5, register-file address width.
- CNT_W, 2, multi-cycle instruction counter width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  6  stall vector from ctrl: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
- flush  in  1  synchronous pipeline flush (exception/ctrl).
- ex_wd  in  ADDR_W  destination register from EX.
- ex_wreg  in  1  register write enable from EX.
- ex_wdata  in  DATA_W  write-back data from EX.
- ex_hi  in  DATA_W  HI value from EX.
- ex_lo  in  DATA_W  LO value from EX.
- ex_whilo  in  1  HI/LO write enable from EX.
- hilo_i  in  2*DATA_W  partial product/accumulation from EX.
- cnt_i  in  CNT_W  EX multi-cycle counter.
- mem_wd  out  ADDR_W  registered destination register to MEM.
- mem_wreg  out  1  registered write enable.
- mem_wdata  out  DATA_W  registered write data.
- mem_hi  out  DATA_W  registered HI.
- mem_lo  out  DATA_W  registered LO.
- mem_whilo  out  1  registered HI/LO write enable.
- hilo_o  out  2*DATA_W  held partial accumulation back to EX.
- cnt_o  out  CNT_W  held counter back to EX.

Behaviour:
- Reset (rst==0, asynchronous, any time): all outputs 0.
  - mem_wd = 0 (NOP register address); mem_wreg = 0; mem_whilo = 0.
  - mem_wdata, mem_hi, mem_lo, hilo_o, cnt_o all 0.
  - Reset mid multi-cycle op discards the accumulation.
- Per rising edge with rst==1, evaluate in priority order:
  1. flush==1: load the bubble into the mem_* outputs (all zero, both enables 0); hilo_o = 0; cnt_o = 0. Flush beats stall.
  2. stall[3]==1 && stall[4]==0 (EX stalled, MEM free):
     - Insert the bubble into the mem_* outputs.
     - Capture hilo_o <= hilo_i and cnt_o <= cnt_i so EX can finish madd/msub next cycle.
  3. stall[3]==0 (EX advancing):
     - mem_* <= ex_* (all six fields).
     - hilo_o <= 0; cnt_o <= 0.
  4. Otherwise (stall[3]==1 && stall[4]==1): hold every output unchanged.
- Latency: exactly 1 cycle from EX inputs to mem_* outputs. No combinational path from inputs to outputs.
- Widths: no arithmetic. hilo_i / hilo_o carry {hi, lo}, with hi in bits [2*DATA_W-1:DATA_W].
- An instruction is never duplicated or dropped across stall sequences. Only a bubble is inserted, and only in case 2.
- Each stalled cycle in case 2 re-captures hilo_i/cnt_i, so the last captured value wins.

Test Plan:
- Reset: assert rst=0 asynchronously mid-cycle with nonzero state -> all outputs 0 immediately, before the next clk edge.
- Pass-through: stall=0, ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h1234_5678, ex_hi=32'hA, ex_lo=32'hB, ex_whilo=1 -> next edge: same values on mem_*, hilo_o=0, cnt_o=0.
- madd two-cycle:
  - Cycle 1: stall=6'b001111, hilo_i=64'h0000_0001_0000_0002, cnt_i=2'd1 -> mem_wreg=0, mem_whilo=0, hilo_o=64'h0000_0001_0000_0002, cnt_o=1.
  - Cycle 2: stall=0, ex_whilo=1, ex_hi=32'h1, ex_lo=32'h5 -> mem_hi=1, mem_lo=5, mem_whilo=1, cnt_o=0.
- Full hold: load ex_wdata=32'hDEAD_BEEF, then stall=6'b011111 for 3 cycles while ex_* change -> mem_wdata stays 32'hDEAD_BEEF and hilo_o/cnt_o unchanged.
- Flush priority: flush=1 with stall=6'b001111 and valid ex_* -> mem_wreg=0, mem_whilo=0, mem_wd=0, hilo_o=0, cnt_o=0.
- Back-to-back: 4 consecutive distinct writes (wd=1..4, wdata=32'h11..32'h44) with stall=0 -> appear on mem_* in order, one per cycle, none lost or repeated.
